// File: rtl/md5_padder_if.sv
// Byte-stream input and block/handshake output bundle for md5_padder.
// The slave modport is the padder's view; master is the producer/core side.
interface md5_padder_if;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_start;
  logic         blk_resume;
  logic         core_done;
  logic         msg_done;
  logic         busy;

  modport slave (
    input  in_data, in_valid, in_last, core_done,
    output in_ready, blk_data, blk_start, blk_resume, msg_done, busy
  );

  modport master (
    output in_data, in_valid, in_last, core_done,
    input  in_ready, blk_data, blk_start, blk_resume, msg_done, busy
  );
endinterface

// File: rtl/md5_padder.sv
// MD5 front end: packs a byte stream into 512-bit blocks (byte k at bits
// [8k+:8]), appends 0x80, zero fill and the 64-bit little-endian bit length,
// and hands each block to the compression core with a start/resume pulse.
// Optional macro MD5_PAD_PREFETCH_EN adds a second buffer that keeps
// accepting message bytes while the core works on a non-final block.
module md5_padder #(
  parameter int unsigned CNT_W = 61
) (
  input  logic         clk,
  input  logic         rst,
  md5_padder_if.slave  bus
);
  localparam int unsigned BLK_W = 512;
  localparam int unsigned IDX_W = 7;
  localparam int unsigned LEN_W = 64;
  localparam logic [IDX_W-1:0] IDX_FULL = 7'd64;
  localparam logic [IDX_W-1:0] IDX_LEN  = 7'd56;

  typedef enum logic [2:0] {IDLE, FILL, PAD, LEN, ISSUE, WAIT} state_t;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [BLK_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             chain_q, chain_d;
  logic             final_q, final_d;
  logic             pad80_q, pad80_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             start_q, start_d;
  logic             resume_q, resume_d;
  logic             done_q, done_d;
  logic             accept_c;
`ifdef MD5_PAD_PREFETCH_EN
  logic [BLK_W-1:0] alt_q, alt_d;
  logic [IDX_W-1:0] alt_idx_q, alt_idx_d;
  logic             alt_last_q, alt_last_d;
`endif

  assign accept_c = bus.in_valid & ready_q;

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    buf_d    = buf_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    chain_d  = chain_q;
    final_d  = final_q;
    pad80_d  = pad80_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef MD5_PAD_PREFETCH_EN
    alt_d      = alt_q;
    alt_idx_d  = alt_idx_q;
    alt_last_d = alt_last_q;
`endif

    unique case (state_q)
      IDLE, FILL: begin
        state_d = FILL;
        if (accept_c) begin
          buf_d[{idx_q[5:0], 3'b000} +: 8] = bus.in_data;
          idx_d  = idx_q + 7'd1;
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
          if (idx_d == IDX_FULL) begin
            state_d = ISSUE;
            ret_d   = bus.in_last ? PAD : FILL;
          end else if (bus.in_last) begin
            state_d = PAD;
          end
        end
      end

      PAD: begin
        buf_d[{idx_q[5:0], 3'b000} +: 8] = pad80_q ? 8'h00 : 8'h80;
        pad80_d = 1'b1;
        idx_d   = idx_q + 7'd1;
        if (idx_d == IDX_FULL) begin
          state_d = ISSUE;
          ret_d   = PAD;
        end else if (idx_d == IDX_LEN) begin
          state_d = LEN;
        end
      end

      LEN: begin
        buf_d[BLK_W-1 -: LEN_W] = LEN_W'({cnt_q, 3'b000});
        final_d = 1'b1;
        state_d = ISSUE;
      end

      ISSUE: begin
        chain_d = 1'b1;
        state_d = WAIT;
      end

      WAIT: begin
`ifdef MD5_PAD_PREFETCH_EN
        if (accept_c) begin
          alt_d[{alt_idx_q[5:0], 3'b000} +: 8] = bus.in_data;
          alt_idx_d = alt_idx_q + 7'd1;
          cnt_d     = cnt_q + CNT_W'(1);
          if (bus.in_last) alt_last_d = 1'b1;
        end
`endif
        if (bus.core_done) begin
          idx_d = '0;
          buf_d = '0;
          if (final_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            chain_d = 1'b0;
            final_d = 1'b0;
            pad80_d = 1'b0;
            state_d = IDLE;
          end else begin
`ifdef MD5_PAD_PREFETCH_EN
            buf_d = alt_d;
            idx_d = alt_idx_d;
            if (alt_idx_d == IDX_FULL) begin
              state_d = ISSUE;
              ret_d   = alt_last_d ? PAD : FILL;
            end else if (alt_last_d) begin
              state_d = PAD;
            end else begin
              state_d = ret_q;
            end
            alt_d      = '0;
            alt_idx_d  = '0;
            alt_last_d = 1'b0;
`else
            state_d = ret_q;
`endif
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Pulses and ready are registered from next-state so they line up with it.
    start_d  = (state_d == ISSUE) && !chain_q;
    resume_d = (state_d == ISSUE) && chain_q;
    ready_d  = (state_d == IDLE) || (state_d == FILL);
`ifdef MD5_PAD_PREFETCH_EN
    if ((state_d == WAIT) && !final_d && (ret_d == FILL) &&
        !alt_last_d && (alt_idx_d != IDX_FULL)) begin
      ready_d = 1'b1;
    end
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ret_q      <= FILL;
      buf_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      chain_q    <= 1'b0;
      final_q    <= 1'b0;
      pad80_q    <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      start_q    <= 1'b0;
      resume_q   <= 1'b0;
      done_q     <= 1'b0;
`ifdef MD5_PAD_PREFETCH_EN
      alt_q      <= '0;
      alt_idx_q  <= '0;
      alt_last_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      buf_q      <= buf_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      chain_q    <= chain_d;
      final_q    <= final_d;
      pad80_q    <= pad80_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      start_q    <= start_d;
      resume_q   <= resume_d;
      done_q     <= done_d;
`ifdef MD5_PAD_PREFETCH_EN
      alt_q      <= alt_d;
      alt_idx_q  <= alt_idx_d;
      alt_last_q <= alt_last_d;
`endif
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.blk_data   = buf_q;
  assign bus.blk_start  = start_q;
  assign bus.blk_resume = resume_q;
  assign bus.msg_done   = done_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_md5_padder.sv
// Directed bench for md5_padder: a background core model answers each block
// pulse with core_done after a programmable delay and captures the blocks.
module tb_md5_padder;
  typedef logic [7:0] bytes_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  md5_padder_if bus();
  md5_padder dut (.clk(clk), .rst(rst), .bus(bus));

  int nchk = 0;
  int nerr = 0;

  logic auto_done = 1'b0;
  logic spur_done = 1'b0;
  assign bus.core_done = auto_done | spur_done;

  int done_delay = 68;
  int pend = -1;
  int cyc = 0;
  int done_cyc = 0;
  int msg_cyc = 0;
  int msg_cnt = 0;
  int hold_err = 0;
  logic [511:0] held = '0;
  logic [511:0] cap_q[$];
  bit kind_q[$];

  // Core model: capture each block on its pulse, answer with core_done later.
  always @(negedge clk) begin
    cyc++;
    auto_done = 1'b0;
    if (!rst) begin
      pend = -1;
    end else begin
      if (bus.msg_done) begin
        msg_cnt++;
        msg_cyc = cyc;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (bus.blk_data !== held) hold_err++;
          auto_done = 1'b1;
          done_cyc = cyc;
          pend = -1;
        end
      end
      if (bus.blk_start || bus.blk_resume) begin
        cap_q.push_back(bus.blk_data);
        kind_q.push_back(bus.blk_start);
        held = bus.blk_data;
        if (done_delay == 0) begin
          auto_done = 1'b1;
          pend = -1;
        end else begin
          pend = done_delay;
        end
      end
    end
  end

  function automatic logic [511:0] fill(input logic [7:0] v, input int n);
    logic [511:0] b;
    b = '0;
    for (int k = 0; k < n; k++) b[8*k +: 8] = v;
    return b;
  endfunction

  function automatic logic [511:0] put(input logic [511:0] b, input int k, input logic [7:0] v);
    logic [511:0] r;
    r = b;
    r[8*k +: 8] = v;
    return r;
  endfunction

  function automatic logic [511:0] cap_at(input int i);
    if (i < cap_q.size()) return cap_q[i];
    return 'x;
  endfunction

  function automatic int kind_at(input int i);
    if (i < kind_q.size()) return int'(kind_q[i]);
    return -1;
  endfunction

  task automatic send_msg(input bytes_t m);
    int i = 0;
    int guard = 0;
    while (i < m.size() && guard < 5000) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = m[i];
      bus.in_last  = (i == m.size() - 1);
      if (bus.in_ready) i++;
      guard++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic wait_cap(input int n, input int lim);
    int k = 0;
    while (cap_q.size() < n && k < lim) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_msg(input int n, input int lim);
    int k = 0;
    while (msg_cnt < n && k < lim) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    nchk++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    nchk++; if (bus.blk_data !== 512'd0) begin nerr++; $display("FAIL rst_blk_data: got %h want 0", bus.blk_data); end
    nchk++; if ({bus.blk_start, bus.blk_resume, bus.msg_done} !== 3'b000) begin nerr++; $display("FAIL rst_pulses: got %b want 000", {bus.blk_start, bus.blk_resume, bus.msg_done}); end
    nchk++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    nchk++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL post_rst_in_ready: got %b want 1", bus.in_ready); end
    nchk++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL post_rst_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_100_bytes();
    bytes_t m;
    logic [511:0] e1, e2;
    int base;
    cap_q.delete(); kind_q.delete();
    base = msg_cnt; hold_err = 0; done_delay = 68;
    for (int i = 0; i < 100; i++) m.push_back(8'h58);
    e1 = fill(8'h58, 64);
    e2 = put(put(put(fill(8'h58, 36), 36, 8'h80), 56, 8'h20), 57, 8'h03);
    send_msg(m);
    nchk++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL b100_busy_mid: got %b want 1", bus.busy); end
    wait_msg(base + 1, 1000);
    nchk++; if (cap_q.size() !== 2) begin nerr++; $display("FAIL b100_nblk: got %0d want 2", cap_q.size()); end
    nchk++; if (cap_at(0) !== e1) begin nerr++; $display("FAIL b100_blk1: got %h want %h", cap_at(0), e1); end
    nchk++; if (kind_at(0) !== 1) begin nerr++; $display("FAIL b100_start: got %0d want 1", kind_at(0)); end
    nchk++; if (cap_at(1) !== e2) begin nerr++; $display("FAIL b100_blk2: got %h want %h", cap_at(1), e2); end
    nchk++; if (kind_at(1) !== 0) begin nerr++; $display("FAIL b100_resume: got %0d want 0", kind_at(1)); end
    nchk++; if (msg_cnt !== base + 1) begin nerr++; $display("FAIL b100_msg_done: got %0d want %0d", msg_cnt, base + 1); end
    nchk++; if (hold_err !== 0) begin nerr++; $display("FAIL b100_hold: got %0d want 0", hold_err); end
    nchk++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL b100_busy_end: got %b want 0", bus.busy); end
  endtask

  task automatic test_abc();
    bytes_t m;
    logic [511:0] e;
    int base;
    cap_q.delete(); kind_q.delete();
    base = msg_cnt; done_delay = 68;
    m = {8'h61, 8'h62, 8'h63};
    e = put(put(put(put(fill(8'h00, 0), 0, 8'h61), 1, 8'h62), 2, 8'h63), 3, 8'h80);
    e = put(e, 56, 8'h18);
    send_msg(m);
    wait_msg(base + 1, 500);
    nchk++; if (cap_q.size() !== 1) begin nerr++; $display("FAIL abc_nblk: got %0d want 1", cap_q.size()); end
    nchk++; if (cap_at(0) !== e) begin nerr++; $display("FAIL abc_blk: got %h want %h", cap_at(0), e); end
    nchk++; if (kind_at(0) !== 1) begin nerr++; $display("FAIL abc_start: got %0d want 1", kind_at(0)); end
    nchk++; if (msg_cnt !== base + 1) begin nerr++; $display("FAIL abc_msg_done: got %0d want %0d", msg_cnt, base + 1); end
    nchk++; if (msg_cyc - done_cyc !== 1) begin nerr++; $display("FAIL abc_done_lat: got %0d want 1", msg_cyc - done_cyc); end
  endtask

  task automatic test_56_zeros();
    bytes_t m;
    logic [511:0] e1, e2;
    int base;
    cap_q.delete(); kind_q.delete();
    base = msg_cnt; done_delay = 68;
    for (int i = 0; i < 56; i++) m.push_back(8'h00);
    e1 = put(fill(8'h00, 0), 56, 8'h80);
    e2 = put(put(fill(8'h00, 0), 56, 8'hC0), 57, 8'h01);
    send_msg(m);
    wait_msg(base + 1, 1000);
    nchk++; if (cap_q.size() !== 2) begin nerr++; $display("FAIL z56_nblk: got %0d want 2", cap_q.size()); end
    nchk++; if (cap_at(0) !== e1) begin nerr++; $display("FAIL z56_blk1: got %h want %h", cap_at(0), e1); end
    nchk++; if (cap_at(1) !== e2) begin nerr++; $display("FAIL z56_blk2: got %h want %h", cap_at(1), e2); end
    nchk++; if ({kind_at(0), kind_at(1)} !== {32'sd1, 32'sd0}) begin nerr++; $display("FAIL z56_kinds: got %0d,%0d want 1,0", kind_at(0), kind_at(1)); end
  endtask

  task automatic test_64_ff();
    bytes_t m;
    logic [511:0] e1, e2;
    int base;
    cap_q.delete(); kind_q.delete();
    base = msg_cnt; done_delay = 68;
    for (int i = 0; i < 64; i++) m.push_back(8'hFF);
    e1 = fill(8'hFF, 64);
    e2 = put(put(fill(8'h00, 0), 0, 8'h80), 57, 8'h02);
    send_msg(m);
    wait_msg(base + 1, 1000);
    nchk++; if (cap_q.size() !== 2) begin nerr++; $display("FAIL f64_nblk: got %0d want 2", cap_q.size()); end
    nchk++; if (cap_at(0) !== e1) begin nerr++; $display("FAIL f64_blk1: got %h want %h", cap_at(0), e1); end
    nchk++; if (cap_at(1) !== e2) begin nerr++; $display("FAIL f64_blk2: got %h want %h", cap_at(1), e2); end
    nchk++; if ({kind_at(0), kind_at(1)} !== {32'sd1, 32'sd0}) begin nerr++; $display("FAIL f64_kinds: got %0d,%0d want 1,0", kind_at(0), kind_at(1)); end
  endtask

  task automatic test_spurious_done();
    bytes_t m;
    logic [511:0] e;
    int base;
    cap_q.delete(); kind_q.delete();
    base = msg_cnt;
    e = put(put(put(put(put(fill(8'h00, 0), 0, 8'h61), 1, 8'h62), 2, 8'h63), 3, 8'h80), 56, 8'h18);
    @(negedge clk); spur_done = 1'b1;
    @(negedge clk); spur_done = 1'b0;
    done_delay = 0;
    m = {8'h61, 8'h62, 8'h63};
    send_msg(m);
    wait_cap(1, 200);
    repeat (20) @(negedge clk);
    nchk++; if (msg_cnt !== base) begin nerr++; $display("FAIL spur_ignored: got %0d want %0d", msg_cnt, base); end
    nchk++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL spur_busy: got %b want 1", bus.busy); end
    spur_done = 1'b1;
    @(negedge clk); spur_done = 1'b0;
    wait_msg(base + 1, 50);
    nchk++; if (msg_cnt !== base + 1) begin nerr++; $display("FAIL spur_real_done: got %0d want %0d", msg_cnt, base + 1); end
    nchk++; if (cap_at(0) !== e) begin nerr++; $display("FAIL spur_blk: got %h want %h", cap_at(0), e); end
    nchk++; if (cap_q.size() !== 1) begin nerr++; $display("FAIL spur_nblk: got %0d want 1", cap_q.size()); end
    done_delay = 68;
  endtask

  task automatic test_reset_in_wait();
    bytes_t m;
    logic [511:0] e;
    int base;
    cap_q.delete(); kind_q.delete();
    done_delay = 68;
    for (int i = 0; i < 100; i++) m.push_back(8'h58);
    send_msg(m);
    wait_cap(2, 500);
    repeat (5) @(negedge clk);
    nchk++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL wait_in_ready: got %b want 0", bus.in_ready); end
    nchk++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL wait_busy: got %b want 1", bus.busy); end
    rst = 1'b0;
    #1;
    nchk++; if (bus.blk_data !== 512'd0) begin nerr++; $display("FAIL rstw_blk_data: got %h want 0", bus.blk_data); end
    nchk++; if ({bus.in_ready, bus.blk_start, bus.blk_resume, bus.msg_done, bus.busy} !== 5'b00000) begin nerr++; $display("FAIL rstw_outs: got %b want 00000", {bus.in_ready, bus.blk_start, bus.blk_resume, bus.msg_done, bus.busy}); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cap_q.delete(); kind_q.delete();
    base = msg_cnt;
    m = {8'h61, 8'h62, 8'h63};
    e = put(put(put(put(put(fill(8'h00, 0), 0, 8'h61), 1, 8'h62), 2, 8'h63), 3, 8'h80), 56, 8'h18);
    send_msg(m);
    wait_msg(base + 1, 500);
    nchk++; if (cap_at(0) !== e) begin nerr++; $display("FAIL rstw_abc_blk: got %h want %h", cap_at(0), e); end
    nchk++; if (kind_at(0) !== 1) begin nerr++; $display("FAIL rstw_abc_start: got %0d want 1", kind_at(0)); end
    nchk++; if (msg_cnt !== base + 1) begin nerr++; $display("FAIL rstw_abc_done: got %0d want %0d", msg_cnt, base + 1); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_100_bytes();
    test_abc();
    test_56_zeros();
    test_64_ff();
    test_spurious_done();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
